// File: rtl/muldiv_unit_pkg.sv
// ============================================================================
//  Module      : muldiv_unit_pkg
//  Description : Shared definitions for the multi-cycle multiply/divide unit.
//                Holds the opcode encodings, the FSM state type and small
//                opcode-decoding helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package muldiv_unit_pkg;

    // Opcodes presented on the op port
    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MADD  = 3'd4;
    localparam logic [2:0] MD_MSUB  = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_MUL     = 3'd1,
        ST_ACC     = 3'd2,
        ST_DIV_RUN = 3'd3,
        ST_DIV_FIX = 3'd4,
        ST_DONE    = 3'd5
    } md_state_t;

    function automatic logic md_is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    // Everything except the two unsigned opcodes is treated as signed; the
    // unused encodings 6/7 therefore behave as a signed multiply.
    function automatic logic md_is_signed(input logic [2:0] op);
        return (op != MD_MULTU) && (op != MD_DIVU);
    endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_unit_div_iter.sv
// ============================================================================
//  Module      : muldiv_unit_div_iter
//  Description : WIDTH-cycle restoring divider core on unsigned magnitudes.
//                One quotient bit per cycle. done is high for one cycle once
//                all WIDTH steps have been taken; q/r hold until next start.
//  Ports       : clk, rst (async, active-high), flush (abort),
//                start (load a_mag/b_mag), a_mag, b_mag -> q, r, done
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_unit_div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             start,
    input  logic [WIDTH-1:0] a_mag,
    input  logic [WIDTH-1:0] b_mag,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic [CW-1:0]    r_cnt;
    logic             r_active;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_fits;

    // Partial remainder shifted left, pulling in the next dividend bit. It
    // needs one extra bit since it can reach 2*divisor-1.
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_fits  = (w_shift >= {1'b0, r_div});
    assign w_diff  = w_shift - {1'b0, r_div};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_cnt    <= '0;
            r_active <= 1'b0;
        end else if (flush) begin
            r_cnt    <= '0;
            r_active <= 1'b0;
        end else if (start) begin
            r_rem    <= '0;
            r_quo    <= a_mag;
            r_div    <= b_mag;
            r_cnt    <= CW'(WIDTH);
            r_active <= 1'b1;
        end else if (r_active) begin
            if (r_cnt != '0) begin
                r_rem <= w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
                r_quo <= {r_quo[WIDTH-2:0], w_fits};
                r_cnt <= r_cnt - 1'b1;
            end else begin
                r_active <= 1'b0;
            end
        end
    end

    assign q    = r_quo;
    assign r    = r_rem;
    assign done = r_active && (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
//  Module      : muldiv_unit
//  Description : Multi-cycle multiply/divide unit for the EX stage. One op is
//                taken through a valid/ready handshake; a 2*WIDTH {HI,LO}
//                result is presented with a one-cycle res_valid pulse.
//  Ports       : clk, rst (async, active-high), flush,
//                op_valid/op_ready handshake, op, src_a, src_b, hilo_in,
//                res_valid, res_hilo, busy (stall), div_by_zero
//  Config      : MULDIV_ACCUM_EN - when defined, MD_MADD/MD_MSUB accumulate
//                into hilo_in with one extra cycle; otherwise they act as
//                MD_MULT and no accumulator adder exists.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               op_valid,
    output logic               op_ready,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   src_a,
    input  logic [WIDTH-1:0]   src_b,
    input  logic [2*WIDTH-1:0] hilo_in,
    output logic               res_valid,
    output logic [2*WIDTH-1:0] res_hilo,
    output logic               busy,
    output logic               div_by_zero
);

    localparam int MCW = $clog2(MUL_LAT + 1);

    md_state_t          r_state;
    md_state_t          w_state_nxt;

    logic               w_accept;
    logic               w_sgn;
    logic               w_acc_op;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH-1:0]   w_div_q;
    logic [WIDTH-1:0]   w_div_r;
    logic [WIDTH-1:0]   w_q_fix;
    logic [WIDTH-1:0]   w_r_fix;
    logic               w_div_done;
    logic [2*WIDTH-1:0] w_a_ext;
    logic [2*WIDTH-1:0] w_b_ext;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_mul_out;
    logic [2*WIDTH-1:0] w_div_res;
    logic [2*WIDTH-1:0] w_res_nxt;

    logic [2*WIDTH-1:0] r_mul_pipe [MUL_LAT];
    logic [MCW-1:0]     r_mcnt;
    logic [WIDTH-1:0]   r_a;
    logic               r_q_neg;
    logic               r_r_neg;
    logic               r_dbz;
    logic [2*WIDTH-1:0] r_res_hilo;

`ifdef MULDIV_ACCUM_EN
    logic               r_acc_en;
    logic               r_acc_sub;
    logic [2*WIDTH-1:0] r_hilo;
    logic [2*WIDTH-1:0] r_acc;
`endif

    assign w_accept = op_valid && (r_state == ST_IDLE) && !flush;
    assign w_sgn    = md_is_signed(op);

    // ------------------------------------------------------------------
    // Multiply: operands are W+1-bit values (sign or zero extended); the
    // low 2W bits of their product equal the low 2W bits of the product of
    // the same values extended all the way to 2W, so the multiply is done
    // at 2W directly. Stage 0 captures the product at the accept edge,
    // so the last stage is ready in time for the DONE transition.
    // ------------------------------------------------------------------
    assign w_a_ext = {{WIDTH{w_sgn & src_a[WIDTH-1]}}, src_a};
    assign w_b_ext = {{WIDTH{w_sgn & src_b[WIDTH-1]}}, src_b};
    assign w_prod  = w_a_ext * w_b_ext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MUL_LAT; i++) r_mul_pipe[i] <= '0;
        end else begin
            r_mul_pipe[0] <= w_prod;
            for (int i = 1; i < MUL_LAT; i++) r_mul_pipe[i] <= r_mul_pipe[i-1];
        end
    end

    assign w_mul_out = r_mul_pipe[MUL_LAT-1];

    // ------------------------------------------------------------------
    // Divide: magnitudes into the core, signs reapplied in DIV_FIX.
    // Signed MIN has magnitude 2^(W-1), which still fits unsigned W bits.
    // ------------------------------------------------------------------
    assign w_a_mag = (w_sgn && src_a[WIDTH-1]) ? (~src_a + 1'b1) : src_a;
    assign w_b_mag = (w_sgn && src_b[WIDTH-1]) ? (~src_b + 1'b1) : src_b;

    muldiv_unit_div_iter #(
        .WIDTH (WIDTH)
    ) u_div_iter (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .start (w_accept && md_is_div(op)),
        .a_mag (w_a_mag),
        .b_mag (w_b_mag),
        .q     (w_div_q),
        .r     (w_div_r),
        .done  (w_div_done)
    );

    assign w_q_fix   = r_q_neg ? (~w_div_q + 1'b1) : w_div_q;
    assign w_r_fix   = r_r_neg ? (~w_div_r + 1'b1) : w_div_r;
    // Divide by zero reports the raw dividend, not the sign-fixed remainder.
    assign w_div_res = r_dbz ? {r_a, {WIDTH{1'b1}}} : {w_r_fix, w_q_fix};

`ifdef MULDIV_ACCUM_EN
    assign w_acc_op = r_acc_en;
`else
    assign w_acc_op = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_res_nxt   = w_mul_out;
        if (flush) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:    if (op_valid) w_state_nxt = md_is_div(op) ? ST_DIV_RUN : ST_MUL;
                ST_MUL:     if (r_mcnt == '0) w_state_nxt = w_acc_op ? ST_ACC : ST_DONE;
                ST_ACC: begin
                    w_state_nxt = ST_DONE;
`ifdef MULDIV_ACCUM_EN
                    w_res_nxt   = r_acc;
`endif
                end
                ST_DIV_RUN: if (w_div_done) w_state_nxt = ST_DIV_FIX;
                ST_DIV_FIX: begin
                    w_state_nxt = ST_DONE;
                    w_res_nxt   = w_div_res;
                end
                ST_DONE:    w_state_nxt = ST_IDLE;
                default:    w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Operand latches, multiply counter, result register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mcnt     <= '0;
            r_a        <= '0;
            r_q_neg    <= 1'b0;
            r_r_neg    <= 1'b0;
            r_dbz      <= 1'b0;
            r_res_hilo <= '0;
`ifdef MULDIV_ACCUM_EN
            r_acc_en   <= 1'b0;
            r_acc_sub  <= 1'b0;
            r_hilo     <= '0;
            r_acc      <= '0;
`endif
        end else begin
            if (w_accept) begin
                r_mcnt    <= MCW'(MUL_LAT - 1);
                r_a       <= src_a;
                r_q_neg   <= w_sgn && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                r_r_neg   <= w_sgn && src_a[WIDTH-1];
                r_dbz     <= md_is_div(op) && (src_b == '0);
`ifdef MULDIV_ACCUM_EN
                r_acc_en  <= (op == MD_MADD) || (op == MD_MSUB);
                r_acc_sub <= (op == MD_MSUB);
                r_hilo    <= hilo_in;
`endif
            end else if (r_state == ST_MUL && r_mcnt != '0) begin
                r_mcnt <= r_mcnt - 1'b1;
            end
`ifdef MULDIV_ACCUM_EN
            if (r_state == ST_MUL && w_state_nxt == ST_ACC)
                r_acc <= r_acc_sub ? (r_hilo - w_mul_out) : (r_hilo + w_mul_out);
`endif
            if (w_state_nxt == ST_DONE && r_state != ST_DONE)
                r_res_hilo <= w_res_nxt;
        end
    end

    assign op_ready    = (r_state == ST_IDLE);
    assign busy        = (r_state != ST_IDLE);
    assign res_valid   = (r_state == ST_DONE);
    assign div_by_zero = (r_state == ST_DONE) && r_dbz;
    assign res_hilo    = r_res_hilo;

endmodule

`default_nettype wire
